pipeline_hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 16 +
 rtl/load_use_detect.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller.
//   State encoding (2'd3 is illegal and recovers to RUN), ID/EX M-field bit
//   positions, and register-number / counter widths.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  localparam int unsigned M_MEMREAD  = 1;
  localparam int unsigned M_MEMWRITE = 0;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
//   idex_M       : ID/EX M field (bit1 MemRead, bit0 MemWrite)
//   idex_rt      : destination of the load sitting in EX
//   ifid_rs      : rs source of the instruction in ID
//   ifid_rt      : rt field of the instruction in ID
//   ifid_uses_rt : ID instruction reads rt as a source
//   load_use     : ID must stall one cycle behind the load
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [1:0]       idex_M,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  output logic             load_use
);

  // Stores never produce a load-use dependency.
  logic unused_memwrite;
  assign unused_memwrite = idex_M[M_MEMWRITE];

  // $zero is never a real dependency.
  assign load_use = idex_M[M_MEMREAD] & (idex_rt != '0) &
                    ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
//   clk, reset    : clock, synchronous active-high reset
//   idex_*/ifid_* : load-use hazard inputs
//   branch_taken  : EX resolved a taken branch/jump
//   dmem_req/ready: data-memory handshake from MEM
//   *_write/*_flush: pipeline register enables and bubble/NOP controls
//   stall_cycles  : saturating count of cycles with pc_write=0
//   mem_timeout   : sticky, memory wait reached MEM_TIMEOUT cycles
//   state_o       : FSM state for debug
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       idex_M,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout,
  output logic [1:0]       state_o
);

  localparam logic [3:0]       FlushLoad = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] WaitMax   = CNT_W'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             timeout_q;
  logic             load_use, mem_stall;

  load_use_detect u_load_use_detect (
    .idex_M      (idex_M),
    .idex_rt     (idex_rt),
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt),
    .ifid_uses_rt(ifid_uses_rt),
    .load_use    (load_use)
  );

  assign mem_stall = dmem_req & ~dmem_ready;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = '0;
          state_d = MEM_WAIT;
          if (state_q == RUN) begin
            wait_cnt_d = CNT_W'(1);
          end else if (wait_cnt_q < WaitMax) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          // Leaving MEM_WAIT re-evaluates the RUN rules in the same cycle.
          wait_cnt_d = '0;
          state_d    = RUN;
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d     = FLUSH;
              flush_cnt_d = FlushLoad;
            end
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (mem_stall) begin
          {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = '0;
        end else begin
          // load_use ignored: the ID instruction is being squashed anyway.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (branch_taken) begin
            flush_cnt_d = FlushLoad;
          end else if (flush_cnt_q <= 4'd1) begin
            state_d     = RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d     = RUN;
        flush_cnt_d = '0;
        wait_cnt_d  = '0;
      end
    endcase

    if (reset) begin
      {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = '0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      if (!pc_write && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (state_q == MEM_WAIT && wait_cnt_q == WaitMax) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign mem_timeout  = timeout_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl
// (FLUSH_CYCLES=2, MEM_TIMEOUT=3).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  idex_M;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        ifid_uses_rt, branch_taken, dmem_req, dmem_ready;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic        exmem_write, memwb_write, mem_timeout;
  logic [15:0] stall_cycles;
  logic [1:0]  state_o;
  logic [6:0]  outs;

  int compared = 0;
  int mismatched = 0;
  int exp_stall = 0;

  // {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w}
  localparam logic [6:0] OutIdle   = 7'b1101011;
  localparam logic [6:0] OutReset  = 7'b0010100;
  localparam logic [6:0] OutLdUse  = 7'b0001111;
  localparam logic [6:0] OutBranch = 7'b1111111;
  localparam logic [6:0] OutFreeze = 7'b0000000;

  assign outs = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                 exmem_write, memwb_write};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .idex_M      (idex_M),
    .idex_rt     (idex_rt),
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt),
    .ifid_uses_rt(ifid_uses_rt),
    .branch_taken(branch_taken),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_write  (idex_write),
    .idex_flush  (idex_flush),
    .exmem_write (exmem_write),
    .memwb_write (memwb_write),
    .stall_cycles(stall_cycles),
    .mem_timeout (mem_timeout),
    .state_o     (state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    idex_M = 2'b00; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    ifid_uses_rt = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    tick();
    tick();
    #1;
    compared++;
    if (outs !== OutReset) begin
      mismatched++; $display("FAIL reset_outs: got %b want %b", outs, OutReset);
    end
    reset = 1'b0;
    #1;
    compared++;
    if (outs !== OutIdle) begin
      mismatched++; $display("FAIL post_reset_outs: got %b want %b", outs, OutIdle);
    end
    compared++;
    if ({state_o, stall_cycles, mem_timeout} !== 19'd0) begin
      mismatched++;
      $display("FAIL post_reset_regs: got state=%0d stall=%0d to=%b want 0/0/0",
               state_o, stall_cycles, mem_timeout);
    end
  endtask

  task automatic test_load_use();
    // rs match
    idex_M = 2'b10; idex_rt = 5'd8; ifid_rs = 5'd8;
    #1;
    compared++;
    if (outs !== OutLdUse) begin
      mismatched++; $display("FAIL ldu_rs_outs: got %b want %b", outs, OutLdUse);
    end
    tick();
    exp_stall++;
    set_idle();
    #1;
    compared++;
    if (outs !== OutIdle) begin
      mismatched++; $display("FAIL ldu_one_bubble: got %b want %b", outs, OutIdle);
    end
    compared++;
    if (stall_cycles !== 16'(exp_stall)) begin
      mismatched++; $display("FAIL ldu_stall_cnt: got %0d want %0d", stall_cycles, exp_stall);
    end
    // rt match only counts when the ID instruction reads rt
    idex_M = 2'b10; idex_rt = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9; ifid_uses_rt = 1'b0;
    #1;
    compared++;
    if (outs !== OutIdle) begin
      mismatched++; $display("FAIL ldu_rt_unused: got %b want %b", outs, OutIdle);
    end
    ifid_uses_rt = 1'b1;
    #1;
    compared++;
    if (outs !== OutLdUse) begin
      mismatched++; $display("FAIL ldu_rt_used: got %b want %b", outs, OutLdUse);
    end
    tick();
    exp_stall++;
    // store to same register is not a load-use
    idex_M = 2'b01;
    #1;
    compared++;
    if (outs !== OutIdle) begin
      mismatched++; $display("FAIL ldu_store: got %b want %b", outs, OutIdle);
    end
    set_idle();
  endtask

  task automatic test_zero_guard();
    idex_M = 2'b10; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b1;
    #1;
    compared++;
    if (outs !== OutIdle) begin
      mismatched++; $display("FAIL zero_guard_outs: got %b want %b", outs, OutIdle);
    end
    tick();
    set_idle();
    compared++;
    if (stall_cycles !== 16'(exp_stall)) begin
      mismatched++; $display("FAIL zero_guard_cnt: got %0d want %0d", stall_cycles, exp_stall);
    end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1;
    #1;
    compared++;
    if ({state_o, outs} !== {2'd0, OutBranch}) begin
      mismatched++;
      $display("FAIL br_cycle1: got st=%0d %b want st=0 %b", state_o, outs, OutBranch);
    end
    tick();
    branch_taken = 1'b0;
    #1;
    compared++;
    if ({state_o, outs} !== {2'd2, OutBranch}) begin
      mismatched++;
      $display("FAIL br_cycle2: got st=%0d %b want st=2 %b", state_o, outs, OutBranch);
    end
    tick();
    compared++;
    if ({state_o, outs} !== {2'd0, OutIdle}) begin
      mismatched++;
      $display("FAIL br_done: got st=%0d %b want st=0 %b", state_o, outs, OutIdle);
    end
  endtask

  task automatic test_mem_wait();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      compared++;
      if (outs !== OutFreeze) begin
        mismatched++; $display("FAIL memwait_freeze%0d: got %b want %b", i, outs, OutFreeze);
      end
      tick();
      exp_stall++;
    end
    dmem_ready = 1'b1;
    #1;
    compared++;
    if ({state_o, outs} !== {2'd1, OutIdle}) begin
      mismatched++;
      $display("FAIL memwait_release: got st=%0d %b want st=1 %b", state_o, outs, OutIdle);
    end
    tick();
    set_idle();
    compared++;
    if ({state_o, stall_cycles} !== {2'd0, 16'(exp_stall)}) begin
      mismatched++;
      $display("FAIL memwait_after: got st=%0d stall=%0d want st=0 stall=%0d",
               state_o, stall_cycles, exp_stall);
    end
  endtask

  task automatic test_flush_freeze();
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0; dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    compared++;
    if ({state_o, outs} !== {2'd2, OutFreeze}) begin
      mismatched++;
      $display("FAIL flush_freeze: got st=%0d %b want st=2 %b", state_o, outs, OutFreeze);
    end
    tick();
    exp_stall++;
    dmem_req = 1'b0;
    #1;
    compared++;
    if ({state_o, outs} !== {2'd2, OutBranch}) begin
      mismatched++;
      $display("FAIL flush_hold: got st=%0d %b want st=2 %b", state_o, outs, OutBranch);
    end
    tick();
    compared++;
    if ({state_o, stall_cycles} !== {2'd0, 16'(exp_stall)}) begin
      mismatched++;
      $display("FAIL flush_exit: got st=%0d stall=%0d want st=0 stall=%0d",
               state_o, stall_cycles, exp_stall);
    end
  endtask

  task automatic test_timeout();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_stall = 0;
    #1;
    compared++;
    if (mem_timeout !== 1'b0) begin
      mismatched++; $display("FAIL to_cleared: got %b want 0", mem_timeout);
    end
    dmem_req = 1'b1; dmem_ready = 1'b0;
    // wait_cnt reaches 3 on the third MEM_WAIT cycle; flag sets at that edge
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_stall++;
      compared++;
      if (mem_timeout !== (i >= 4)) begin
        mismatched++; $display("FAIL to_cycle%0d: got %b want %b", i, mem_timeout, (i >= 4));
      end
    end
    dmem_ready = 1'b1;
    tick();
    set_idle();
    tick();
    compared++;
    if ({state_o, mem_timeout} !== {2'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL to_sticky: got st=%0d to=%b want st=0 to=1", state_o, mem_timeout);
    end
  endtask

  task automatic test_simultaneous();
    dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
    idex_M = 2'b10; idex_rt = 5'd4; ifid_rs = 5'd4;
    #1;
    compared++;
    if (outs !== OutFreeze) begin
      mismatched++; $display("FAIL sim_freeze: got %b want %b", outs, OutFreeze);
    end
    tick();
    set_idle();
    compared++;
    if (state_o !== 2'd1) begin
      mismatched++; $display("FAIL sim_state: got %0d want 1", state_o);
    end
    tick();
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    reset = 1'b1;
    #1;
    compared++;
    if ({state_o, outs} !== {2'd2, OutReset}) begin
      mismatched++;
      $display("FAIL sim_reset_outs: got st=%0d %b want st=2 %b", state_o, outs, OutReset);
    end
    tick();
    reset = 1'b0;
    #1;
    compared++;
    if ({state_o, stall_cycles, mem_timeout} !== 19'd0) begin
      mismatched++;
      $display("FAIL sim_reset_regs: got st=%0d stall=%0d to=%b want 0/0/0",
               state_o, stall_cycles, mem_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_guard();
    test_branch();
    test_mem_wait();
    test_flush_freeze();
    test_timeout();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
